// File: rtl/countdown_sched.sv
// countdown_sched: round-robin arbiter sharing one down-counter among NREQ timer clients.
// Optional pause input under `define COUNTDOWN_SCHED_PAUSE_EN (freezes the count while RUN).
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high reset
//   pause    in   (COUNTDOWN_SCHED_PAUSE_EN only) hold count/state while RUN
//   req      in   [NREQ]      per-requester request level
//   len      in   [NREQ*dw]   flattened lengths, len[i*dw +: dw] = requester i
//   grant    out  [NREQ]      one-hot counter owner, zero when idle
//   busy     out  1           job in RUN or DONE
//   count    out  [dw]        current counter value
//   done     out  1           one-cycle completion pulse
//   done_id  out  [IDW]       owner of last completed job, held between pulses
module countdown_sched #(
  parameter int dw   = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
`ifdef COUNTDOWN_SCHED_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*dw-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [dw-1:0]      count,
  output logic               done,
  output logic [IDW-1:0]     done_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [dw-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;

  logic run_hold;

`ifdef COUNTDOWN_SCHED_PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  // Arbitration: rotate req so that bit 0 is the requester at rr_q,
  // take the lowest set bit, then add the offset back modulo NREQ.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDW:0]      off;
  logic [IDW:0]      wsum;
  logic              found;
  logic [IDW-1:0]    win;
  logic [dw-1:0]     win_len;
  logic [IDW-1:0]    win_nxt;

  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[rr_q +: NREQ];
    off     = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        off   = (IDW+1)'(k);
      end
    end
    wsum = {1'b0, rr_q} + off;
    if (wsum >= (IDW+1)'(NREQ)) begin
      wsum = wsum - (IDW+1)'(NREQ);
    end
    win = wsum[IDW-1:0];
  end

  always_comb begin
    win_len = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IDW'(k)) begin
        win_len = len[k*dw +: dw];
      end
    end
  end

  always_comb begin
    if (win == IDW'(NREQ-1)) begin
      win_nxt = '0;
    end else begin
      win_nxt = win + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = (win_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (!run_hold && count_q <= dw'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output / datapath next values; all outputs leave from registers.
  // done is raised on the same edge that enters DONE, so it lines up
  // with the DONE cycle without a combinational decode.
  always_comb begin
    rr_d      = rr_q;
    cur_id_d  = cur_id_q;
    grant_d   = grant_q;
    count_d   = count_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          cur_id_d = win;
          grant_d  = NREQ'(1) << win;
          count_d  = win_len;
          rr_d     = win_nxt;
          if (win_len == '0) begin
            done_d    = 1'b1;
            done_id_d = win;
          end
        end
      end
      S_RUN: begin
        if (!run_hold) begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end
          if (count_q <= dw'(1)) begin
            done_d    = 1'b1;
            done_id_d = cur_id_q;
          end
        end
      end
      S_DONE: begin
        grant_d = '0;
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q      <= '0;
      cur_id_q  <= '0;
      grant_q   <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      rr_q      <= rr_d;
      cur_id_q  <= cur_id_d;
      grant_q   <= grant_d;
      count_q   <= count_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);
  assign count   = count_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule
